// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for a 5-stage pipeline: hazard priority, drain/halt
// handshake, saturating performance counters and a sticky data-memory timeout flag.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halt_ack,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_DEPTH + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_DEPTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_halt_ack;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_count;

  logic w_mem_stall;
  logic w_load_use;
  logic w_advance;
  logic w_count_stall;
  logic w_count_flush;
  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_flush, w_exmem_we, w_memwb_we;

  assign w_mem_stall = dmem_req & ~dmem_ready;
  assign w_load_use  = ex_memread & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // Per-cycle stage control: memory wait beats branch beats load-use.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_we     = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_we    = 1'b0;
    w_memwb_we    = 1'b0;
    w_advance     = 1'b0;
    w_count_stall = 1'b0;
    w_count_flush = 1'b0;

    if (r_state == S_HALTED) begin
      w_ifid_we    = 1'b1;
      w_ifid_flush = 1'b1;
      w_idex_we    = 1'b1;
      w_idex_flush = 1'b1;
      w_exmem_we   = 1'b1;
      w_memwb_we   = 1'b1;
    end else begin
      if (w_mem_stall) begin
        w_count_stall = 1'b1;
      end else if (branch_taken) begin
        // The ID instruction is squashed, so a coincident load-use is moot.
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_we     = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_we    = 1'b1;
        w_memwb_we    = 1'b1;
        w_advance     = 1'b1;
        w_count_flush = 1'b1;
      end else if (w_load_use) begin
        w_idex_we     = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_we    = 1'b1;
        w_memwb_we    = 1'b1;
        w_count_stall = 1'b1;
      end else begin
        w_pc_we    = 1'b1;
        w_ifid_we  = 1'b1;
        w_idex_we  = 1'b1;
        w_exmem_we = 1'b1;
        w_memwb_we = 1'b1;
        w_advance  = 1'b1;
      end

      // While draining, fetch is stopped and only bubbles enter IF/ID.
      if (r_state == S_DRAIN) begin
        w_pc_we = 1'b0;
        if (w_ifid_we) w_ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = S_RUN;
    case (r_state)
      S_RUN:    w_next_state = halt_req ? S_DRAIN : S_RUN;
      S_DRAIN: begin
        if (!halt_req)                                 w_next_state = S_RUN;
        else if (w_advance && r_drain_cnt == DRAIN_LAST) w_next_state = S_HALTED;
        else                                           w_next_state = S_DRAIN;
      end
      S_HALTED: w_next_state = halt_req ? S_HALTED : S_RUN;
      default:  w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_drain_cnt    <= '0;
      r_halt_ack     <= 1'b0;
      r_wait_cnt     <= '0;
      r_timeout_err  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_next_state;
      r_halt_ack <= (w_next_state == S_HALTED);

      if (r_state != S_DRAIN)  r_drain_cnt <= '0;
      else if (w_advance)      r_drain_cnt <= r_drain_cnt + 1'b1;

      if (w_mem_stall) begin
        if (r_wait_cnt != WAIT_MAX)  r_wait_cnt    <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == WAIT_LAST) r_timeout_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_count_stall && r_stall_cycles != {CNT_W{1'b1}})
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_count_flush && r_flush_count != {CNT_W{1'b1}})
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  // Enables are forced low for the whole time reset is held, not just at the edge.
  assign pc_we        = rst_n & w_pc_we;
  assign ifid_we      = rst_n & w_ifid_we;
  assign ifid_flush   = rst_n & w_ifid_flush;
  assign idex_we      = rst_n & w_idex_we;
  assign idex_flush   = rst_n & w_idex_flush;
  assign exmem_we     = rst_n & w_exmem_we;
  assign memwb_we     = rst_n & w_memwb_we;
  assign halt_ack     = r_halt_ack;
  assign timeout_err  = r_timeout_err;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written sequences for stall, timeout, drain/halt, saturation and reset.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int DRAIN_DEPTH = 4;
  localparam int CNT_W       = 4;

  // Enable vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}
  localparam logic [6:0] EN_NORMAL = 7'b1101011;
  localparam logic [6:0] EN_LU     = 7'b0001111;
  localparam logic [6:0] EN_BRANCH = 7'b1111111;
  localparam logic [6:0] EN_FROZEN = 7'b0000000;
  localparam logic [6:0] EN_DRAIN  = 7'b0111011;
  localparam logic [6:0] EN_HALTED = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rt, ex_memread, branch_taken, dmem_req, dmem_ready, halt_req;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
  logic halt_ack, timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .DRAIN_DEPTH(DRAIN_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .halt_req    (halt_req),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_we     (idex_we),
    .idex_flush  (idex_flush),
    .exmem_we    (exmem_we),
    .memwb_we    (memwb_we),
    .halt_ack    (halt_ack),
    .timeout_err (timeout_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp_en;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [6:0] en();
    return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_en(input string name, input logic [6:0] exp);
    check(name, 32'(en()), 32'(exp));
  endtask

  task automatic idle();
    ex_memread   = 1'b0;
    ex_rd        = 5'd0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    branch_taken = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic load_use();
    ex_memread = 1'b1;
    ex_rd      = 5'd5;
    id_rs      = 5'd5;
  endtask

  task automatic mem_wait();
    dmem_req   = 1'b1;
    dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    halt_req = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL};
    tbl[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_LU};
    tbl[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EN_NORMAL};
    tbl[3]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, EN_LU};
    tbl[4]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL};
    tbl[5]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, EN_NORMAL};
    tbl[6]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, EN_BRANCH};
    tbl[7]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, EN_FROZEN};
    tbl[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EN_NORMAL};
    tbl[9]  = '{1'b1, 5'd3, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, EN_NORMAL};
    tbl[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FROZEN};

    halt_req = 1'b0;
    idle();

    // Reset state, sampled while reset is still held
    #2;
    check_en("reset enables", EN_FROZEN);
    check("reset halt_ack", 32'(halt_ack), 32'd0);
    check("reset timeout", 32'(timeout_err), 32'd0);
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
    do_reset();

    // Table of RUN-state priority vectors
    for (int i = 0; i < 11; i++) begin
      ex_memread   = tbl[i].memread;
      ex_rd        = tbl[i].rd;
      id_rs        = tbl[i].rs;
      id_rt        = tbl[i].rt;
      id_uses_rt   = tbl[i].uses_rt;
      branch_taken = tbl[i].br;
      dmem_req     = tbl[i].req;
      dmem_ready   = tbl[i].rdy;
      @(negedge clk);
      check_en($sformatf("vector %0d enables", i), tbl[i].exp_en);
      tick();
    end
    idle();
    check("table stall_cycles", 32'(stall_cycles), 32'd4);
    check("table flush_count", 32'(flush_count), 32'd1);
    check("table timeout", 32'(timeout_err), 32'd0);

    // Load-use: one bubble, then ex_rd=0 never stalls, then branch overrides
    do_reset();
    load_use();
    @(negedge clk);
    check_en("load-use enables", EN_LU);
    tick();
    check("load-use stall_cycles", 32'(stall_cycles), 32'd1);
    ex_rd = 5'd0;
    id_rs = 5'd0;
    @(negedge clk);
    check_en("rd0 no stall", EN_NORMAL);
    tick();
    check("rd0 stall_cycles", 32'(stall_cycles), 32'd1);
    load_use();
    branch_taken = 1'b1;
    @(negedge clk);
    check_en("branch over load-use", EN_BRANCH);
    tick();
    check("branch flush_count", 32'(flush_count), 32'd1);
    check("branch stall_cycles", 32'(stall_cycles), 32'd1);
    idle();

    // Memory wait for 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_wait();
      @(negedge clk);
      check_en($sformatf("mem wait %0d", i), EN_FROZEN);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check_en("mem ready", EN_NORMAL);
    tick();
    idle();
    check("mem wait stall_cycles", 32'(stall_cycles), 32'd3);
    check("mem wait timeout", 32'(timeout_err), 32'd0);

    // Timeout after MEM_TIMEOUT consecutive wait cycles, sticky until reset
    do_reset();
    mem_wait();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("timeout after stall %0d", i + 1), 32'(timeout_err), 32'(i >= 3));
    end
    idle();
    tick();
    check("timeout sticky", 32'(timeout_err), 32'd1);
    do_reset();
    check("timeout cleared by reset", 32'(timeout_err), 32'd0);

    // Halt with no hazards
    do_reset();
    halt_req = 1'b1;
    @(negedge clk);
    check("halt request cycle pc_we", 32'(pc_we), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_en($sformatf("drain %0d enables", i), EN_DRAIN);
      check($sformatf("drain %0d halt_ack", i), 32'(halt_ack), 32'd0);
      tick();
    end
    check("halt_ack after drain", 32'(halt_ack), 32'd1);
    load_use();
    @(negedge clk);
    check_en("halted enables", EN_HALTED);
    tick();
    check("halted counters frozen", 32'(stall_cycles), 32'd0);
    idle();
    halt_req = 1'b0;
    @(negedge clk);
    check("halt_ack held in release cycle", 32'(halt_ack), 32'd1);
    tick();
    check("halt_ack after release", 32'(halt_ack), 32'd0);
    @(negedge clk);
    check_en("run after release", EN_NORMAL);

    // Halt with one memory stall during drain: ack one cycle later
    halt_req = 1'b1;
    tick();
    tick();
    mem_wait();
    @(negedge clk);
    check_en("drain mem stall", EN_FROZEN);
    tick();
    idle();
    tick();
    tick();
    check("halt_ack delayed by stall", 32'(halt_ack), 32'd0);
    tick();
    check("halt_ack after stalled drain", 32'(halt_ack), 32'd1);
    check("drain stall counted", 32'(stall_cycles), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset while halted halt_ack", 32'(halt_ack), 32'd0);
    do_reset();

    // Async reset mid-drain with non-zero counters and timeout set
    load_use();
    tick();
    idle();
    mem_wait();
    for (int i = 0; i < 4; i++) tick();
    idle();
    halt_req = 1'b1;
    tick();
    tick();
    load_use();
    @(negedge clk);
    check_en("drain load-use", EN_LU);
    tick();
    idle();
    tick();
    check("pre-reset stall_cycles", 32'(stall_cycles), 32'd6);
    check("pre-reset timeout", 32'(timeout_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_en("async reset enables", EN_FROZEN);
    check("async reset halt_ack", 32'(halt_ack), 32'd0);
    check("async reset stall_cycles", 32'(stall_cycles), 32'd0);
    check("async reset flush_count", 32'(flush_count), 32'd0);
    check("async reset timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_en("run after async reset", EN_NORMAL);
    halt_req = 1'b0;
    tick();

    // Counter saturation
    do_reset();
    mem_wait();
    for (int i = 0; i < 20; i++) tick();
    idle();
    check("stall_cycles saturates", 32'(stall_cycles), 32'd15);
    branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    idle();
    check("flush_count saturates", 32'(flush_count), 32'd15);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
